// File: rtl/stream_rr_arbiter.sv
// rtl/stream_rr_arbiter.sv - round-robin stream arbiter with per-packet lock
// A winner keeps the output until it sends a beat with last set; the search then restarts after it.
module stream_rr_arbiter #(
  parameter int DATA_SIZE = 8,
  parameter int NUM_REQ   = 4,
  localparam int IdW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_clk_ni,
  input  logic [NUM_REQ*DATA_SIZE-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]           req_valid_i,
  input  logic [NUM_REQ-1:0]           req_last_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  output logic [DATA_SIZE-1:0]         data_o,
  output logic                         data_last_o,
  output logic                         data_valid_o,
  input  logic                         data_ready_i,
  output logic [IdW-1:0]               grant_id_o
);

  typedef enum logic {StArbitrate, StLocked} state_e;

  state_e               state_q, state_d;
  logic [IdW-1:0]       ptr_q, ptr_d, lock_id_q, lock_id_d, sel;
  logic                 found, out_free, accept, sel_valid, sel_last;
  logic [DATA_SIZE-1:0] sel_data;

  // Two passes: requesters at or above ptr_q first, then the wrapped-around lower ones.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    if (state_q == StLocked) begin
      sel   = lock_id_q;
      found = 1'b1;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req_valid_i[i] && (IdW'(i) >= ptr_q)) begin
          found = 1'b1;
          sel   = IdW'(i);
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req_valid_i[i]) begin
          found = 1'b1;
          sel   = IdW'(i);
        end
      end
    end
  end

  always_comb begin
    sel_data  = '0;
    sel_last  = 1'b0;
    sel_valid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IdW'(i) == sel) begin
        sel_data  = req_data_i[i*DATA_SIZE +: DATA_SIZE];
        sel_last  = req_last_i[i];
        sel_valid = req_valid_i[i];
      end
    end
  end

  assign out_free = !data_valid_o || data_ready_i;
  assign accept   = out_free && found && sel_valid;

  // While locked, ready follows the lock owner alone, not its valid.
  always_comb begin
    req_ready_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready_o[i] = rst_clk_ni && out_free && found && (IdW'(i) == sel);
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    lock_id_d = lock_id_q;
    if (accept) begin
      if (sel_last) begin
        state_d = StArbitrate;
        ptr_d   = (sel == IdW'(NUM_REQ - 1)) ? '0 : sel + IdW'(1);
      end else begin
        state_d = StLocked;
        if (state_q == StArbitrate) lock_id_d = sel;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_clk_ni) begin
    if (!rst_clk_ni) begin
      state_q      <= StArbitrate;
      ptr_q        <= '0;
      lock_id_q    <= '0;
      data_valid_o <= 1'b0;
      data_o       <= '0;
      data_last_o  <= 1'b0;
      grant_id_o   <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      lock_id_q <= lock_id_d;
      if (accept) begin
        data_valid_o <= 1'b1;
        data_o       <= sel_data;
        data_last_o  <= sel_last;
        grant_id_o   <= sel;
      end else if (data_ready_i) begin
        data_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// tb/tb_stream_rr_arbiter.sv - self-checking bench for stream_rr_arbiter
module tb_stream_rr_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [N-1:0] vld = '0;
  logic [N-1:0] lst = '0;
  logic [W-1:0] d [N];
  logic         rdy = 1'b1;
  logic [N*W-1:0] req_data;
  logic [N-1:0] req_ready;
  logic [W-1:0] data_o;
  logic         data_last, data_valid;
  logic [1:0]   gid;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int q_gid[$], q_data[$], q_last[$], q_cyc[$];

  bit m_locked, m_vld;
  int m_ptr, m_lock, m_data, m_last, m_gid;

  assign req_data = {d[3], d[2], d[1], d[0]};
  always #5 clk = ~clk;

  stream_rr_arbiter #(.DATA_SIZE(W), .NUM_REQ(N)) dut (
    .clk_i(clk), .rst_clk_ni(rst_n), .req_data_i(req_data), .req_valid_i(vld),
    .req_last_i(lst), .req_ready_o(req_ready), .data_o(data_o), .data_last_o(data_last),
    .data_valid_o(data_valid), .data_ready_i(rdy), .grant_id_o(gid)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Who is entitled to send this cycle: the lock owner, else the first valid requester from ptr.
  function automatic int pick();
    if (m_locked) return m_lock;
    for (int k = 0; k < N; k++) if (vld[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin : model
    int p;
    bit free;
    if (!rst_n) begin
      m_locked <= 0; m_vld <= 0; m_ptr <= 0; m_lock <= 0;
      m_data <= 0; m_last <= 0; m_gid <= 0;
    end else begin
      p = pick();
      free = !m_vld || rdy;
      if (free && p >= 0 && vld[p]) begin
        m_vld <= 1; m_data <= int'(d[p]); m_last <= int'(lst[p]); m_gid <= p;
        if (lst[p]) begin
          m_locked <= 0;
          m_ptr <= (p + 1) % N;
        end else begin
          m_locked <= 1;
          m_lock <= p;
        end
      end else if (rdy) begin
        m_vld <= 0;
      end
    end
  end

  always @(negedge clk) begin : compare
    int p;
    logic [N-1:0] er;
    if (rst_n) begin
      er = '0;
      p = pick();
      if ((!m_vld || rdy) && p >= 0) er[p] = 1'b1;
      chk("req_ready", req_ready, er);
      chk("data_valid", data_valid, m_vld);
      if (m_vld) begin
        chk("data", data_o, m_data);
        chk("last", data_last, m_last);
        chk("grant_id", gid, m_gid);
      end
      if (data_valid && rdy) begin
        q_gid.push_back(int'(gid)); q_data.push_back(int'(data_o));
        q_last.push_back(int'(data_last)); q_cyc.push_back(cyc);
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    vld = '0; lst = '0; rdy = 1'b1; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    q_gid.delete(); q_data.delete(); q_last.delete(); q_cyc.delete();
  endtask

  task automatic check_beat(string tag, int i, int g, int dd, int l);
    if (i >= q_gid.size()) begin
      checks++; errors++;
      $display("FAIL %s beat %0d: got missing expected gid %0d data %0h", tag, i, g, dd);
    end else begin
      chk({tag, "_gid"}, q_gid[i], g);
      chk({tag, "_data"}, q_data[i], dd);
      chk({tag, "_last"}, q_last[i], l);
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) d[i] = '0;
    vld = 4'hF; lst = 4'hF;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_valid", data_valid, 0); chk("rst_data", data_o, 0);
    chk("rst_last", data_last, 0); chk("rst_gid", gid, 0); chk("rst_ready", req_ready, 0);

    // Round robin, one beat per cycle
    do_reset();
    chk("idle_ready", req_ready, 0);
    for (int i = 0; i < N; i++) d[i] = 8'hA0 + 8'(i);
    vld = 4'hF; lst = 4'hF;
    tick(1);
    chk("rr_latency_valid", data_valid, 1); chk("rr_latency_gid", gid, 0);
    tick(4);
    vld = '0; tick(2);
    chk("rr_count", q_gid.size(), 5);
    check_beat("rr", 0, 0, 8'hA0, 1); check_beat("rr", 1, 1, 8'hA1, 1);
    check_beat("rr", 2, 2, 8'hA2, 1); check_beat("rr", 3, 3, 8'hA3, 1);
    check_beat("rr", 4, 0, 8'hA0, 1);
    for (int i = 1; i < q_cyc.size(); i++) chk("rr_back_to_back", q_cyc[i] - q_cyc[i-1], 1);

    // Packet lock
    do_reset();
    vld = 4'b0011; lst = 4'b0010; d[0] = 8'h10; d[1] = 8'h20;
    tick(1); d[0] = 8'h11;
    tick(1); d[0] = 8'h12; lst = 4'b0011;
    tick(1); vld = 4'b0010;
    tick(1); vld = '0;
    tick(2);
    chk("lock_count", q_gid.size(), 4);
    check_beat("lock", 0, 0, 8'h10, 0); check_beat("lock", 1, 0, 8'h11, 0);
    check_beat("lock", 2, 0, 8'h12, 1); check_beat("lock", 3, 1, 8'h20, 1);

    // Back-pressure with a held beat
    do_reset();
    rdy = 1'b0; vld = 4'b0001; lst = 4'b0011; d[0] = 8'h30; d[1] = 8'h31;
    tick(1); vld = 4'b0010;
    repeat (5) begin
      tick(1);
      chk("bp_valid", data_valid, 1); chk("bp_data", data_o, 8'h30);
      chk("bp_gid", gid, 0); chk("bp_ready", req_ready, 0);
    end
    rdy = 1'b1;
    tick(1);
    chk("bp_reload_data", data_o, 8'h31); chk("bp_reload_gid", gid, 1);
    vld = '0; tick(2);
    chk("bp_count", q_gid.size(), 2);
    check_beat("bp", 0, 0, 8'h30, 1); check_beat("bp", 1, 1, 8'h31, 1);

    // Pointer wrap from 3 to 0
    do_reset();
    vld = 4'b0100; lst = 4'b1101; d[2] = 8'h40; d[3] = 8'h43; d[0] = 8'h44;
    tick(1); vld = 4'b1001;
    tick(2); vld = '0;
    tick(2);
    chk("wrap_count", q_gid.size(), 3);
    check_beat("wrap", 0, 2, 8'h40, 1); check_beat("wrap", 1, 3, 8'h43, 1);
    check_beat("wrap", 2, 0, 8'h44, 1);

    // Asynchronous reset during a locked packet
    do_reset();
    vld = 4'b0100; lst = 4'b0000; d[2] = 8'h50;
    tick(1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", data_valid, 0); chk("mid_rst_data", data_o, 0);
    chk("mid_rst_last", data_last, 0); chk("mid_rst_gid", gid, 0);
    chk("mid_rst_ready", req_ready, 0);
    tick(1);
    vld = 4'b0101; lst = 4'b0101; d[0] = 8'h60; d[2] = 8'h51;
    #2 rst_n = 1'b1;
    q_gid.delete(); q_data.delete(); q_last.delete(); q_cyc.delete();
    #1 chk("post_rst_ready", req_ready, 4'b0001);
    @(posedge clk); #1;
    tick(1); vld = '0;
    tick(2);
    chk("mid_rst_count", q_gid.size(), 2);
    check_beat("mid_rst", 0, 0, 8'h60, 1); check_beat("mid_rst", 1, 2, 8'h51, 1);

    // Lock owner stalls while another requester waits
    do_reset();
    vld = 4'b0010; lst = 4'b0000; d[1] = 8'h70;
    tick(1); vld = 4'b0100; lst = 4'b0100; d[2] = 8'h80;
    repeat (4) begin
      tick(1);
      chk("stall_ready2", req_ready[2], 0);
    end
    vld = 4'b0110; lst = 4'b0110; d[1] = 8'h71;
    tick(1); vld = 4'b0100;
    tick(1); vld = '0;
    tick(2);
    chk("stall_count", q_gid.size(), 3);
    check_beat("stall", 0, 1, 8'h70, 0); check_beat("stall", 1, 1, 8'h71, 1);
    check_beat("stall", 2, 2, 8'h80, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
